// File: rtl/fir_pkg.sv
// Shared types and default parameters for the FIR tap sequencer slice.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fir_seq_state_t;

    localparam int NTAPS_DEF   = 10;
    localparam int MAC_LAT_DEF = 2;

endpackage

// File: rtl/fir_tap_counter.sv
// Loadable, enabled up-counter with a terminal-count flag.
// Used by the sequencer for the tap index and for the MAC drain count.
module fir_tap_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic [W-1:0] last_val,
    output logic [W-1:0] count,
    output logic         tc
);

    logic [W-1:0] count_r;

    // Count register: load has priority over increment, otherwise hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= {W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (en) begin
            count_r <= count_r + W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
    assign tc    = (count_r == last_val);

endmodule

// File: rtl/fir_tap_sequencer.sv
// Frame controller for the time-multiplexed FIR MAC: one frame per new sample,
// stepping the tap index, flagging the first product, draining the MAC pipe and
// pulsing result_capture. A one-deep queue absorbs a sample that arrives mid-frame.
module fir_tap_sequencer
    import fir_pkg::*;
#(
    parameter int NTAPS   = NTAPS_DEF,
    parameter int TAPW    = 8,
    parameter int MAC_LAT = MAC_LAT_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            sample_valid,
    input  logic [TAPW-1:0] eq_sel,
    input  logic            overrun_clr,
    output logic [TAPW-1:0] tapnum,
    output logic [TAPW-1:0] coef_sel,
    output logic            tap_valid,
    output logic            tap_first,
    output logic            mac_ce,
    output logic            result_capture,
    output logic            busy,
    output logic            overrun
);

    localparam int               DRAIN_W    = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam logic [TAPW-1:0]  TAP_LAST   = TAPW'(NTAPS - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(MAC_LAT - 1);

    // tapnum must be able to represent every tap index, and the drain needs at least one cycle
    if ((NTAPS < 1) || (NTAPS > (2 ** TAPW)) || (MAC_LAT < 1)) begin : g_param_check
        $error("fir_tap_sequencer: NTAPS must be 1..2**TAPW and MAC_LAT >= 1");
    end

    fir_seq_state_t      state_r;
    logic [TAPW-1:0]     coef_sel_r;
    logic                tap_valid_r;
    logic                tap_first_r;
    logic                mac_ce_r;
    logic                result_capture_r;
    logic                busy_r;
    logic                overrun_r;
    logic                pending_r;

    logic                start_s;
    logic                tap_en_s;
    logic                drain_load_s;
    logic                drain_en_s;
    logic                tap_tc_s;
    logic                drain_tc_s;
    logic [DRAIN_W-1:0]  drain_cnt_s;
    logic                pending_nxt_s;
    logic                overrun_set_s;

    fir_tap_counter #(.W(TAPW)) u_tap_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (start_s),
        .load_val ({TAPW{1'b0}}),
        .en       (tap_en_s),
        .last_val (TAP_LAST),
        .count    (tapnum),
        .tc       (tap_tc_s)
    );

    fir_tap_counter #(.W(DRAIN_W)) u_drain_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (drain_load_s),
        .load_val ({DRAIN_W{1'b0}}),
        .en       (drain_en_s),
        .last_val (DRAIN_LAST),
        .count    (drain_cnt_s),
        .tc       (drain_tc_s)
    );

    // Frame start and counter control derived from the current state.
    always_comb begin
        start_s      = 1'b0;
        tap_en_s     = 1'b0;
        drain_load_s = 1'b0;
        drain_en_s   = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                start_s = sample_valid | pending_r;
            end
            RUN: begin
                if (tap_tc_s) begin
                    drain_load_s = 1'b1;
                end else begin
                    tap_en_s = 1'b1;
                end
            end
            DRAIN: begin
                if (drain_tc_s) begin
                    drain_en_s = 1'b0;
                end else begin
                    drain_en_s = 1'b1;
                end
            end
            default: begin
                start_s = 1'b0;
            end
        endcase
    end

    // One-deep sample queue: a second mid-frame sample is dropped and flagged.
    always_comb begin
        pending_nxt_s = pending_r;
        overrun_set_s = 1'b0;
        case (state_r)
            IDLE: begin
                pending_nxt_s = 1'b0;
            end
            RUN, DRAIN: begin
                if (sample_valid) begin
                    if (pending_r) begin
                        overrun_set_s = 1'b1;
                        pending_nxt_s = 1'b1;
                    end else begin
                        pending_nxt_s = 1'b1;
                    end
                end else begin
                    pending_nxt_s = pending_r;
                end
            end
            DONE: begin
                // a queued sample restarts now; a coincident new sample takes its queue slot
                pending_nxt_s = sample_valid & pending_r;
            end
            default: begin
                pending_nxt_s = 1'b0;
            end
        endcase
    end

    // Sequencer FSM with registered control outputs aligned to the state they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r          <= IDLE;
            coef_sel_r       <= {TAPW{1'b0}};
            tap_valid_r      <= 1'b0;
            tap_first_r      <= 1'b0;
            mac_ce_r         <= 1'b0;
            result_capture_r <= 1'b0;
            busy_r           <= 1'b0;
            overrun_r        <= 1'b0;
            pending_r        <= 1'b0;
        end else begin
            pending_r <= pending_nxt_s;
            overrun_r <= overrun_set_s | (overrun_r & ~overrun_clr);
            case (state_r)
                IDLE, DONE: begin
                    result_capture_r <= 1'b0;
                    if (start_s) begin
                        state_r     <= RUN;
                        coef_sel_r  <= eq_sel;
                        tap_valid_r <= 1'b1;
                        tap_first_r <= 1'b1;
                        mac_ce_r    <= 1'b1;
                        busy_r      <= 1'b1;
                    end else begin
                        state_r     <= IDLE;
                        tap_valid_r <= 1'b0;
                        tap_first_r <= 1'b0;
                        mac_ce_r    <= 1'b0;
                        busy_r      <= 1'b0;
                    end
                end
                RUN: begin
                    tap_first_r <= 1'b0;
                    if (tap_tc_s) begin
                        state_r     <= DRAIN;
                        tap_valid_r <= 1'b0;
                    end else begin
                        state_r     <= RUN;
                        tap_valid_r <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_tc_s) begin
                        state_r          <= DONE;
                        mac_ce_r         <= 1'b0;
                        result_capture_r <= 1'b1;
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                default: begin
                    state_r          <= IDLE;
                    tap_valid_r      <= 1'b0;
                    tap_first_r      <= 1'b0;
                    mac_ce_r         <= 1'b0;
                    result_capture_r <= 1'b0;
                    busy_r           <= 1'b0;
                end
            endcase
        end
    end

    assign coef_sel       = coef_sel_r;
    assign tap_valid      = tap_valid_r;
    assign tap_first      = tap_first_r;
    assign mac_ce         = mac_ce_r;
    assign result_capture = result_capture_r;
    assign busy           = busy_r;
    assign overrun        = overrun_r;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed self-checking bench for fir_tap_sequencer (NTAPS=10, MAC_LAT=2).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_fir_tap_sequencer;

    logic       clk;
    logic       reset;
    logic       sample_valid;
    logic [7:0] eq_sel;
    logic       overrun_clr;
    logic [7:0] tapnum;
    logic [7:0] coef_sel;
    logic       tap_valid;
    logic       tap_first;
    logic       mac_ce;
    logic       result_capture;
    logic       busy;
    logic       overrun;

    int checks_total;
    int checks_passed;

    fir_tap_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .sample_valid   (sample_valid),
        .eq_sel         (eq_sel),
        .overrun_clr    (overrun_clr),
        .tapnum         (tapnum),
        .coef_sel       (coef_sel),
        .tap_valid      (tap_valid),
        .tap_first      (tap_first),
        .mac_ce         (mac_ce),
        .result_capture (result_capture),
        .busy           (busy),
        .overrun        (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {tap_valid, tap_first, mac_ce, result_capture, busy} for cycle rel after the
    // edge that accepted a sample: RUN 1..10, DRAIN 11..12, DONE 13, idle from 14.
    function automatic logic [4:0] exp_ctl(input int rel);
        logic tv, tf, ce, rc, bz;
        tv = (rel >= 1 && rel <= 10);
        tf = (rel == 1);
        ce = (rel >= 1 && rel <= 12);
        rc = (rel == 13);
        bz = (rel >= 1 && rel <= 13);
        return {tv, tf, ce, rc, bz};
    endfunction

    // Expected tap index for cycle rel (valid for rel 1..12; holds at 9 during drain).
    function automatic logic [7:0] exp_tap(input int rel);
        if (rel <= 10) return 8'(rel - 1);
        return 8'd9;
    endfunction

    task automatic test_reset();
        logic [21:0] obs;
        reset = 1'b0; sample_valid = 1'b0; eq_sel = 8'h00; overrun_clr = 1'b0;
        repeat (2) @(negedge clk);
        obs = {tapnum, coef_sel, tap_valid, tap_first, mac_ce, result_capture, busy, overrun};
        checks_total++;
        if (obs !== 22'd0) $display("FAIL reset_in: got %h expected 0", obs);
        else checks_passed++;
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            obs = {tapnum, coef_sel, tap_valid, tap_first, mac_ce, result_capture, busy, overrun};
            checks_total++;
            if (obs !== 22'd0) $display("FAIL reset_idle[%0d]: got %h expected 0", i, obs);
            else checks_passed++;
        end
    endtask

    // One isolated frame: pulse, then check cycles 1..14 after the accepting edge.
    task automatic check_frame(input logic [7:0] eq, input string tag);
        logic [4:0] ctl;
        eq_sel = eq;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        for (int rel = 1; rel <= 14; rel++) begin
            ctl = {tap_valid, tap_first, mac_ce, result_capture, busy};
            checks_total++;
            if (ctl !== exp_ctl(rel)) $display("FAIL %s ctl@%0d: got %b expected %b", tag, rel, ctl, exp_ctl(rel));
            else checks_passed++;
            if (rel <= 12) begin
                checks_total++;
                if (tapnum !== exp_tap(rel)) $display("FAIL %s tapnum@%0d: got %0d expected %0d", tag, rel, tapnum, exp_tap(rel));
                else checks_passed++;
            end
            if (rel <= 13) begin
                checks_total++;
                if (coef_sel !== eq) $display("FAIL %s coef_sel@%0d: got %h expected %h", tag, rel, coef_sel, eq);
                else checks_passed++;
            end
            if (rel < 14) @(negedge clk);
        end
    endtask

    task automatic test_single_frame();
        check_frame(8'h03, "t2_frame");
    endtask

    task automatic test_back_to_back();
        logic [4:0] ctl;
        int rel;
        eq_sel = 8'h05;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        for (int m = 1; m <= 27; m++) begin
            rel = (m <= 13) ? m : m - 13;
            ctl = {tap_valid, tap_first, mac_ce, result_capture, busy};
            checks_total++;
            if (ctl !== exp_ctl(rel)) $display("FAIL t3_ctl@%0d: got %b expected %b", m, ctl, exp_ctl(rel));
            else checks_passed++;
            if (rel <= 12) begin
                checks_total++;
                if (tapnum !== exp_tap(rel)) $display("FAIL t3_tapnum@%0d: got %0d expected %0d", m, tapnum, exp_tap(rel));
                else checks_passed++;
            end
            checks_total++;
            if (overrun !== 1'b0) $display("FAIL t3_overrun@%0d: got %b expected 0", m, overrun);
            else checks_passed++;
            sample_valid = (m == 5) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        sample_valid = 1'b0;
    endtask

    task automatic test_overrun();
        int n;
        int rc_cnt;
        eq_sel = 8'h01;
        sample_valid = 1'b1;
        @(negedge clk);                      // cycle 1
        sample_valid = 1'b0;
        @(negedge clk);                      // cycle 2
        sample_valid = 1'b1;
        @(negedge clk);                      // cycle 3: queued, no overrun
        sample_valid = 1'b0;
        checks_total++;
        if (overrun !== 1'b0) $display("FAIL t4_queued: got %b expected 0", overrun);
        else checks_passed++;
        sample_valid = 1'b1;
        @(negedge clk);                      // cycle 4: third sample dropped
        sample_valid = 1'b0;
        checks_total++;
        if (overrun !== 1'b1) $display("FAIL t4_set: got %b expected 1", overrun);
        else checks_passed++;
        repeat (3) @(negedge clk);           // cycle 7
        checks_total++;
        if (overrun !== 1'b1) $display("FAIL t4_sticky: got %b expected 1", overrun);
        else checks_passed++;
        overrun_clr = 1'b1;
        @(negedge clk);                      // cycle 8
        overrun_clr = 1'b0;
        checks_total++;
        if (overrun !== 1'b0) $display("FAIL t4_clr: got %b expected 0", overrun);
        else checks_passed++;
        sample_valid = 1'b1;                 // still one queued -> new overrun with clear
        overrun_clr = 1'b1;
        @(negedge clk);                      // cycle 9
        sample_valid = 1'b0;
        overrun_clr = 1'b0;
        checks_total++;
        if (overrun !== 1'b1) $display("FAIL t4_set_wins: got %b expected 1", overrun);
        else checks_passed++;
        n = 0;
        rc_cnt = 0;
        while (busy === 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
            if (result_capture === 1'b1) rc_cnt++;
        end
        checks_total++;
        if (busy !== 1'b0) $display("FAIL t4_idle_timeout: busy %b after %0d cycles, expected 0", busy, n);
        else checks_passed++;
        checks_total++;
        if (rc_cnt !== 2) $display("FAIL t4_frames: got %0d result_capture pulses expected 2", rc_cnt);
        else checks_passed++;
        checks_total++;
        if (overrun !== 1'b1) $display("FAIL t4_still_set: got %b expected 1", overrun);
        else checks_passed++;
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        checks_total++;
        if (overrun !== 1'b0) $display("FAIL t4_final_clr: got %b expected 0", overrun);
        else checks_passed++;
    endtask

    task automatic test_reset_midframe();
        logic [21:0] obs;
        eq_sel = 8'h21;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (4) @(negedge clk);           // cycle 5: tapnum 4
        checks_total++;
        if (tapnum !== 8'd4) $display("FAIL t5_pre_tap: got %0d expected 4", tapnum);
        else checks_passed++;
        reset = 1'b0;
        #1;
        obs = {tapnum, coef_sel, tap_valid, tap_first, mac_ce, result_capture, busy, overrun};
        checks_total++;
        if (obs !== 22'd0) $display("FAIL t5_async: got %h expected 0", obs);
        else checks_passed++;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            checks_total++;
            if ({result_capture, busy} !== 2'b00) $display("FAIL t5_aborted[%0d]: got %b expected 00", i, {result_capture, busy});
            else checks_passed++;
        end
        check_frame(8'h42, "t5_after");
    endtask

    task automatic test_eq_sel_latch();
        eq_sel = 8'h03;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        for (int m = 1; m <= 13; m++) begin
            checks_total++;
            if (coef_sel !== 8'h03) $display("FAIL t6_coef@%0d: got %h expected 03", m, coef_sel);
            else checks_passed++;
            if (m == 3) begin
                checks_total++;
                if (tapnum !== 8'd2) $display("FAIL t6_tap2: got %0d expected 2", tapnum);
                else checks_passed++;
                eq_sel = 8'h07;
            end
            @(negedge clk);
        end
        check_frame(8'h07, "t6_next");
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overrun();
        test_reset_midframe();
        test_eq_sel_latch();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
